// File: rtl/multi_channel_tick_generator_pkg.sv
// Shared definitions for the multi-channel tick generator.
//   ch_state_t   : per-channel state (OFF / RUN / DONE)
//   RST_*        : values every channel returns to on reset
//   ch_width()   : width of a channel index, never less than one bit
package tick_gen_pkg;

  typedef enum logic [1:0] {
    CH_OFF  = 2'd0,
    CH_RUN  = 2'd1,
    CH_DONE = 2'd2
  } ch_state_t;

  // 100 MHz / 50_000_000 gives a 2 Hz tick and a 1 Hz square wave.
  localparam longint unsigned RST_DIV     = 64'd50_000_000;
  localparam ch_state_t       RST_STATE   = CH_RUN;
  localparam logic            RST_ONESHOT = 1'b0;

  function automatic int ch_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/multi_channel_tick_generator_if.sv
// Control/status bundle of the multi-channel tick generator.
//   en         : global run enable (low freezes every channel)
//   wr_en      : one-cycle divisor write strobe
//   wr_ch      : target channel of the write
//   wr_div     : divisor N (0 stops the channel)
//   wr_oneshot : 1 = one-shot, 0 = periodic
//   tick/sq/done : per-channel registered outputs
// master = controller side, slave = generator side.
interface multi_channel_tick_generator_if
  import tick_gen_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 32
);

  localparam int CH_W = ch_width(NUM_CH);

  logic              en;
  logic              wr_en;
  logic [CH_W-1:0]   wr_ch;
  logic [CNT_W-1:0]  wr_div;
  logic              wr_oneshot;
  logic [NUM_CH-1:0] tick;
  logic [NUM_CH-1:0] sq;
  logic [NUM_CH-1:0] done;

  modport master (
    output en, wr_en, wr_ch, wr_div, wr_oneshot,
    input  tick, sq, done
  );

  modport slave (
    input  en, wr_en, wr_ch, wr_div, wr_oneshot,
    output tick, sq, done
  );

endinterface

// File: rtl/multi_channel_tick_generator_tick_channel.sv
// One divider channel: counter, OFF/RUN/DONE state machine and the
// tick / sq / done flops.
//   clk_in, reset_n : clock, asynchronous active-low reset
//   en              : run enable (freezes count and state when low)
//   load            : write strobe for this channel (wins over counting)
//   div, oneshot    : divisor N and mode captured on load
//   tick, sq, done  : registered outputs
module tick_channel
  import tick_gen_pkg::*;
#(
  parameter int               CNT_W    = 32,
  parameter logic [CNT_W-1:0] RST_TERM = CNT_W'(RST_DIV - 1)
) (
  input  logic             clk_in,
  input  logic             reset_n,
  input  logic             en,
  input  logic             load,
  input  logic [CNT_W-1:0] div,
  input  logic             oneshot,
  output logic             tick,
  output logic             sq,
  output logic             done
);

  ch_state_t        state;
  logic [CNT_W-1:0] cnt;
  // Terminal value N-1 is stored at load time so the wrap test is a
  // plain equality; for N=0 the value is irrelevant because OFF never counts.
  logic [CNT_W-1:0] term;
  logic             oneshot_q;

  // NOTE: every flop here is assigned with <= so all of them see the
  // pre-edge values of each other, exactly like the hardware.
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      state     <= RST_STATE;
      cnt       <= '0;
      term      <= RST_TERM;
      oneshot_q <= RST_ONESHOT;
      tick      <= 1'b0;
      sq        <= 1'b0;
      done      <= 1'b0;
    end else if (load) begin
      // A write beats a coincident terminal count: no tick, no toggle.
      state     <= (div == '0) ? CH_OFF : CH_RUN;
      cnt       <= '0;
      term      <= div - CNT_W'(1);
      oneshot_q <= oneshot;
      tick      <= 1'b0;
      sq        <= 1'b0;
      done      <= 1'b0;
    end else begin
      tick <= 1'b0;
      if (en && state == CH_RUN) begin
        if (cnt == term) begin
          cnt  <= '0;
          tick <= 1'b1;
          sq   <= ~sq;
          if (oneshot_q) begin
            state <= CH_DONE;
            done  <= 1'b1;
          end
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/multi_channel_tick_generator.sv
// NUM_CH independent run-time programmable tick dividers.
//   clk_in  : system clock
//   reset_n : asynchronous active-low reset
//   bus     : slave side of multi_channel_tick_generator_if
//             (en, wr_* write port in; tick/sq/done out)
// A write is decoded into a one-hot load strobe; channel indices at or
// above NUM_CH match no strobe and are therefore ignored.
module multi_channel_tick_generator
  import tick_gen_pkg::*;
#(
  parameter int              NUM_CH  = 4,
  parameter int              CNT_W   = 32,
  parameter longint unsigned DEF_DIV = RST_DIV
) (
  input  logic                           clk_in,
  input  logic                           reset_n,
  multi_channel_tick_generator_if.slave  bus
);

  localparam int CH_W = ch_width(NUM_CH);

  logic [NUM_CH-1:0] load;

  // NOTE: load is given a full default before the loop so no path
  // through this block can leave it unassigned and infer a latch.
  always_comb begin
    load = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      load[i] = bus.wr_en && (bus.wr_ch == CH_W'(i));
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    tick_channel #(
      .CNT_W    (CNT_W),
      .RST_TERM (CNT_W'(DEF_DIV - 1))
    ) u_ch (
      .clk_in  (clk_in),
      .reset_n (reset_n),
      .en      (bus.en),
      .load    (load[g]),
      .div     (bus.wr_div),
      .oneshot (bus.wr_oneshot),
      .tick    (bus.tick[g]),
      .sq      (bus.sq[g]),
      .done    (bus.done[g])
    );
  end

endmodule

// File: tb/tb_multi_channel_tick_generator.sv
// Scoreboard bench: stimulus pushes per-channel expected (cycle, tick,
// sq, done) records; a negedge monitor pops and compares them, and any
// tick with no matching record is reported. Channels 0..3 belong to
// dut_a (NUM_CH=4), channels 4..6 to dut_b (NUM_CH=3, used for the
// out-of-range write). Both use DEF_DIV=5.
module tb_multi_channel_tick_generator;

  localparam int NOBS = 7;

  typedef struct {
    int   cyc;
    logic t;
    logic s;
    logic d;
  } exp_t;

  logic clk_in = 1'b0;
  logic reset_n;
  int   cyc = 0;
  int   compared = 0;
  int   mismatched = 0;
  int   r0, r2;

  exp_t exp_q [NOBS][$];

  multi_channel_tick_generator_if #(.NUM_CH(4), .CNT_W(32)) a_if ();
  multi_channel_tick_generator_if #(.NUM_CH(3), .CNT_W(8))  b_if ();

  multi_channel_tick_generator #(.NUM_CH(4), .CNT_W(32), .DEF_DIV(5)) dut_a (
    .clk_in  (clk_in),
    .reset_n (reset_n),
    .bus     (a_if.slave)
  );

  multi_channel_tick_generator #(.NUM_CH(3), .CNT_W(8), .DEF_DIV(5)) dut_b (
    .clk_in  (clk_in),
    .reset_n (reset_n),
    .bus     (b_if.slave)
  );

  always #5 clk_in = ~clk_in;
  always @(posedge clk_in) cyc <= cyc + 1;

  // ---------------- scoreboard helpers ----------------
  task automatic push(input int ch, input int c, input logic t, input logic s, input logic d);
    exp_t e;
    int   i;
    e.cyc = c; e.t = t; e.s = s; e.d = d;
    i = 0;
    while (i < exp_q[ch].size() && exp_q[ch][i].cyc <= c) i++;
    exp_q[ch].insert(i, e);
  endtask

  task automatic tk(input int ch, input int c, input logic s, input logic d);
    push(ch, c, 1'b1, s, d);
  endtask

  task automatic idle(input int ch, input int c, input logic s, input logic d);
    push(ch, c, 1'b0, s, d);
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk_in) begin
    logic [NOBS-1:0] ot, os, od;
    exp_t e;
    ot = {b_if.tick, a_if.tick};
    os = {b_if.sq,   a_if.sq};
    od = {b_if.done, a_if.done};
    for (int ch = 0; ch < NOBS; ch++) begin
      while (exp_q[ch].size() > 0 && exp_q[ch][0].cyc < cyc) begin
        e = exp_q[ch].pop_front();
        compared++;
        mismatched++;
        $display("FAIL missed_check ch%0d: expected record at cyc %0d never reached (now %0d)", ch, e.cyc, cyc);
      end
      if (exp_q[ch].size() > 0 && exp_q[ch][0].cyc == cyc) begin
        e = exp_q[ch].pop_front();
        compared++;
        if ({ot[ch], os[ch], od[ch]} !== {e.t, e.s, e.d}) begin
          mismatched++;
          $display("FAIL out ch%0d cyc %0d (rel %0d): tick/sq/done got %b%b%b want %b%b%b",
                   ch, cyc, cyc - r0, ot[ch], os[ch], od[ch], e.t, e.s, e.d);
        end
      end else if (ot[ch] !== 1'b0) begin
        compared++;
        mismatched++;
        $display("FAIL unexpected_tick ch%0d cyc %0d (rel %0d): got tick=%b want 0",
                 ch, cyc, cyc - r0, ot[ch]);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) step();
  endtask

  // Inputs set now are sampled at the next edge; strobe lasts one cycle.
  task automatic wr_a(input int ch, input int div, input logic os);
    a_if.wr_en      = 1'b1;
    a_if.wr_ch      = 2'(ch);
    a_if.wr_div     = 32'(div);
    a_if.wr_oneshot = os;
    step();
    a_if.wr_en      = 1'b0;
  endtask

  task automatic wr_b(input int ch, input int div, input logic os);
    b_if.wr_en      = 1'b1;
    b_if.wr_ch      = 2'(ch);
    b_if.wr_div     = 8'(div);
    b_if.wr_oneshot = os;
    step();
    b_if.wr_en      = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed stimulus ----------------
  // Edge numbers below are relative to r0, the cycle of reset release.
  initial begin
    r0 = 0;
    reset_n         = 1'b0;
    a_if.en         = 1'b0;
    a_if.wr_en      = 1'b0;
    a_if.wr_ch      = '0;
    a_if.wr_div     = '0;
    a_if.wr_oneshot = 1'b0;
    b_if.en         = 1'b1;
    b_if.wr_en      = 1'b0;
    b_if.wr_ch      = '0;
    b_if.wr_div     = '0;
    b_if.wr_oneshot = 1'b0;
    repeat (3) step();

    reset_n = 1'b1;
    a_if.en = 1'b1;
    r0 = cyc;
    // Reset state, then DEF_DIV=5 ticks on 5, 10, 15.
    for (int ch = 0; ch < NOBS; ch++) idle(ch, r0 + 1, 1'b0, 1'b0);
    for (int ch = 0; ch < 4; ch++) begin
      tk(ch, r0 + 5,  1'b1, 1'b0);
      tk(ch, r0 + 10, 1'b0, 1'b0);
      tk(ch, r0 + 15, 1'b1, 1'b0);
    end
    // dut_b runs untouched until the reset at 57; write to ch3 ignored.
    for (int ch = 4; ch < NOBS; ch++) begin
      for (int m = 1; m <= 11; m++) tk(ch, r0 + 5 * m, logic'(m % 2), 1'b0);
      idle(ch, r0 + 57, 1'b0, 1'b0);
    end
    wait_until(r0 + 11);
    wr_b(3, 1, 1'b0);                       // edge 12, NUM_CH=3 -> ignored

    // ch2 N=3 periodic at edge 17: ticks 20, 23, 26; others keep phase.
    wait_until(r0 + 16);
    tk(0, r0 + 20, 1'b0, 1'b0);
    tk(1, r0 + 20, 1'b0, 1'b0);
    tk(3, r0 + 20, 1'b0, 1'b0);
    tk(2, r0 + 20, 1'b1, 1'b0);
    tk(2, r0 + 23, 1'b0, 1'b0);
    tk(2, r0 + 26, 1'b1, 1'b0);
    wr_a(2, 3, 1'b0);

    // ch1 N=4 one-shot at edge 22: single tick at 26 with done.
    wait_until(r0 + 21);
    tk(1, r0 + 26, 1'b1, 1'b1);
    tk(0, r0 + 25, 1'b1, 1'b0);
    tk(3, r0 + 25, 1'b1, 1'b0);
    wr_a(1, 4, 1'b1);

    // en low on edges 28..34 with ch0/ch3 at count 2 of 5.
    wait_until(r0 + 27);
    idle(0, r0 + 30, 1'b1, 1'b0);
    idle(1, r0 + 30, 1'b1, 1'b1);
    idle(2, r0 + 30, 1'b1, 1'b0);
    idle(3, r0 + 30, 1'b1, 1'b0);
    tk(0, r0 + 37, 1'b0, 1'b0);
    tk(0, r0 + 42, 1'b1, 1'b0);
    tk(3, r0 + 37, 1'b0, 1'b0);
    tk(3, r0 + 42, 1'b1, 1'b0);
    tk(2, r0 + 36, 1'b0, 1'b0);
    tk(2, r0 + 39, 1'b1, 1'b0);
    tk(2, r0 + 42, 1'b0, 1'b0);
    tk(2, r0 + 45, 1'b1, 1'b0);
    tk(2, r0 + 48, 1'b0, 1'b0);
    tk(2, r0 + 51, 1'b1, 1'b0);
    tk(2, r0 + 54, 1'b0, 1'b0);
    a_if.en = 1'b0;
    wait_until(r0 + 34);
    a_if.en = 1'b1;

    // ch3 N=0 at edge 43: OFF clears sq.
    wait_until(r0 + 42);
    idle(3, r0 + 44, 1'b0, 1'b0);
    idle(3, r0 + 47, 1'b0, 1'b0);
    idle(1, r0 + 45, 1'b1, 1'b1);
    wr_a(3, 0, 1'b0);

    // ch0 rewrite at edge 47, its terminal count: no tick there.
    wait_until(r0 + 46);
    idle(0, r0 + 47, 1'b0, 1'b0);
    tk(0, r0 + 52, 1'b1, 1'b0);
    wr_a(0, 5, 1'b0);

    // ch3 N=1 at edge 48: tick every cycle, sq toggles every cycle.
    wait_until(r0 + 47);
    for (int i = 0; i < 6; i++) tk(3, r0 + 49 + i, logic'((i + 1) % 2), 1'b0);
    wr_a(3, 1, 1'b0);

    // ch1 rewrite N=6 periodic at edge 50 clears done.
    wait_until(r0 + 49);
    idle(1, r0 + 51, 1'b0, 1'b0);
    tk(1, r0 + 56, 1'b1, 1'b0);
    wr_a(1, 6, 1'b0);

    // ch3 N=0 at edge 55 coincides with its N=1 terminal count.
    wait_until(r0 + 54);
    idle(3, r0 + 55, 1'b0, 1'b0);
    idle(3, r0 + 56, 1'b0, 1'b0);
    wr_a(3, 0, 1'b0);

    // Reset asserted just after edge 57, which ticked ch0 and ch2.
    wait_until(r0 + 56);
    for (int ch = 0; ch < 4; ch++) idle(ch, r0 + 57, 1'b0, 1'b0);
    step();
    reset_n = 1'b0;

    wait_until(r0 + 60);
    reset_n = 1'b1;
    r2 = cyc;
    for (int ch = 0; ch < NOBS; ch++) begin
      idle(ch, r2 + 1, 1'b0, 1'b0);
      tk(ch, r2 + 5, 1'b1, 1'b0);
    end
    wait_until(r2 + 8);
    @(negedge clk_in);
    #1;

    for (int ch = 0; ch < NOBS; ch++) begin
      if (exp_q[ch].size() != 0) begin
        compared++;
        mismatched++;
        $display("FAIL leftover ch%0d: %0d records unchecked, want 0", ch, exp_q[ch].size());
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/multi_channel_tick_generator.md
# multi_channel_tick_generator

Parametrised successor to the fixed 100 MHz→1 Hz divider. It provides NUM_CH independent divider channels. Each channel has a run-time divisor, a periodic or one-shot mode, a one-cycle `tick` clock-enable and a 50 % square `sq` output. It sits next to the clock/counter logic of the display and timekeeping projects: ticks drive clock enables, and `sq` drives LEDs/buzzers directly.

## Interface
- `NUM_CH`, 4, number of independent channels (1..16).
- `CNT_W`, 32, counter/divisor width in bits.
- `DEF_DIV`, 50_000_000, divisor loaded into every channel at reset. Must fit in CNT_W bits. With 100 MHz it gives `tick` at 2 Hz and `sq` at 1 Hz.
- `clk_in`  in  1  system clock (100 MHz nominal).
- `reset_n`  in  1  asynchronous, active-low reset.
- `en`  in  1  global run enable. Low freezes all channels.
- `wr_en`  in  1  one-cycle divisor write strobe.
- `wr_ch`  in  $clog2(NUM_CH) (min 1)  target channel of the write.
- `wr_div`  in  CNT_W  divisor N. 0 = stop the channel.
- `wr_oneshot`  in  1  1 = one-shot mode, 0 = periodic mode.
- `tick`  out  NUM_CH  per-channel one-cycle pulse every N enabled cycles.
- `sq`  out  NUM_CH  per-channel level, toggles on each tick.
- `done`  out  NUM_CH  per-channel flag, high once a one-shot has fired.

## Operation
- Per-channel state machine:
  - States are OFF, RUN and DONE.
  - Reset → RUN, periodic, N=DEF_DIV.
  - A write with N=0 → OFF.
  - A write with N≥1 → RUN.
  - RUN with one-shot set, on its tick → DONE.
  - OFF and DONE leave only on a write.
- Counter behaviour:
  - In RUN with `en`=1, the counter counts 0..N-1.
  - On the cycle the counter equals N-1 it wraps to 0, and `tick` and `sq` update at that edge.
  - The load stores N-1 as the terminal value, so the compare is a single equality at CNT_W bits. There is no adder on the compare path.
- N=1: `tick` stays high on every enabled cycle and `sq` toggles every cycle.
- `en`=0 freezes the counter and state and forces `tick` low. `sq` and `done` hold their values. Raising `en` resumes from the frozen count with no lost or extra cycles.
- Write handling:
  - A write clears that channel's counter, `sq` and `done` and sets the mode.
  - A write takes effect at the next edge regardless of `en`.
  - A write on the same edge as that channel's terminal count takes priority: no tick, no toggle.
  - Writes to `wr_ch` ≥ NUM_CH are ignored.
  - Channels are fully independent. A write never disturbs the other channels.
- In OFF, `tick`=0 and `sq`=0. In DONE, `tick`=0, `sq` holds its post-tick value (1) and `done`=1.

## Timing
- All outputs are registered directly from flops. No combinational path from inputs to outputs.
- Reset values:
  - `tick`=0, `sq`=0, `done`=0.
  - Counters are 0.
  - All channels are in RUN, periodic, N=DEF_DIV.
- Reset assertion clears all of the above immediately, mid-count included. Counting starts on the first edge after `reset_n` is released.
- Write latency: `wr_en` is sampled at edge k and the counter is 0 after k. With `en` held at 1, the first `tick` is high in the cycle after edge k+N. Later ticks come every N cycles, and the `sq` period is 2N cycles.
- One-shot: exactly one `tick`, N cycles after the write. `done` rises at the same edge as that `tick`.

## Structure
- Package `tick_gen_pkg` holds:
  - the channel state enum (OFF/RUN/DONE);
  - the reset-default constants.
- Sub-module `tick_channel` contains one counter, the state machine and the `tick`/`sq`/`done` flops. The top level decodes `wr_ch` into per-channel load strobes and generate-instantiates NUM_CH copies of `tick_channel`.

## Test plan
- Reset release, `en`=1, DEF_DIV overridden to 5 → every channel ticks on cycles 5, 10, 15 after release. `sq` toggles high at 5 and low at 10. `done` stays 0.
- Write ch2 N=3 periodic at edge k → ch2 ticks at k+3, k+6. Ch0, ch1 and ch3 phases are unchanged.
- Write ch1 N=4 one-shot → a single tick at k+4 with `done[1]`=1 and `sq[1]`=1 afterwards. No further ticks over 20 cycles. A rewrite clears `done[1]`.
- Drop `en` for 7 cycles mid-count (count=2 of N=5) → no ticks while `en`=0. The next tick comes 3 enabled cycles after `en` rises.
- Write N=0, then N=1 → OFF holds `tick`=0 and `sq`=0. With N=1, `tick` is continuously high and `sq` toggles every cycle. A write coinciding with terminal count → no tick on that edge.
- Assert `reset_n` low mid-count with ticks active → all outputs 0 immediately. A write to `wr_ch`=NUM_CH is ignored.
